// File: rtl/cosim_commit_arbiter.sv
// Per-hart commit FIFOs feeding one registered output slot through a round-robin arbiter,
// so a single-threaded co-simulation checker sees one hart's commit record at a time.
module cosim_commit_arbiter #(
  parameter int NUM_HARTS  = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int REC_W      = 168,
  parameter int TIMEOUT    = 1024,
  localparam int HW        = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic [NUM_HARTS-1:0]       commit_valid_i,
  input  logic [NUM_HARTS*REC_W-1:0] commit_rec_i,
  output logic [NUM_HARTS-1:0]       commit_ready_o,
  output logic                       chk_valid_o,
  output logic [HW-1:0]              chk_hart_o,
  output logic [REC_W-1:0]           chk_rec_o,
  input  logic                       chk_ready_i,
  output logic [NUM_HARTS-1:0]       overflow_o,
  output logic                       hang_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic {S_EMPTY, S_PRESENT} state_t;

  state_t               state;
  logic [HW-1:0]        last_grant;
  logic [HW-1:0]        grant;
  logic                 grant_found;
  logic                 load;
  logic [NUM_HARTS-1:0] not_empty;
  logic [REC_W-1:0]     head [NUM_HARTS];
  logic [HW:0]          cand_wide;
  logic [HW-1:0]        cand;
  logic [TW-1:0]        hang_cnt;

  // Rotating priority starting just after the last granted hart; sees FIFO state
  // before this cycle's pushes because not_empty comes from registered counts.
  // NOTE: every variable gets a default at the top of always_comb so no path can
  // leave it unassigned and infer a latch; blocking '=' is correct here because
  // later loop iterations must see earlier results within the same evaluation.
  always_comb begin
    grant       = '0;
    grant_found = 1'b0;
    cand_wide   = '0;
    cand        = '0;
    for (int i = 1; i <= NUM_HARTS; i++) begin
      cand_wide = {1'b0, last_grant} + (HW+1)'(i);
      if (cand_wide >= (HW+1)'(NUM_HARTS)) cand_wide = cand_wide - (HW+1)'(NUM_HARTS);
      cand = cand_wide[HW-1:0];
      if (!grant_found && not_empty[cand]) begin
        grant_found = 1'b1;
        grant       = cand;
      end
    end
  end

  assign load = grant_found && (!chk_valid_o || chk_ready_i) && !flush_i;

  for (genvar h = 0; h < NUM_HARTS; h++) begin : g_fifo
    logic [REC_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             ovf;
    logic             full;
    logic             push;
    logic             pop;

    // Full is judged on the registered count: no write-through on a same-cycle pop.
    assign full              = (count == CW'(FIFO_DEPTH));
    assign push              = commit_valid_i[h] && !full && !flush_i;
    assign pop               = load && (grant == HW'(h));
    assign commit_ready_o[h] = !full;
    assign not_empty[h]      = (count != '0);
    assign head[h]           = mem[rd_ptr];
    assign overflow_o[h]     = ovf;

    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        ovf    <= 1'b0;
      end else if (flush_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        ovf    <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        unique case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: ;
        endcase
        if (commit_valid_i[h] && full) ovf <= 1'b1;
      end
    end

    // NOTE: the storage array has no reset; the pointers and count alone define
    // which entries are meaningful, so clearing the data would only cost logic.
    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= commit_rec_i[h*REC_W +: REC_W];
    end
  end

  // Output slot: a load on the same edge as a handshake keeps one record per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_EMPTY;
      chk_valid_o <= 1'b0;
      chk_hart_o  <= '0;
      chk_rec_o   <= '0;
      last_grant  <= HW'(NUM_HARTS - 1);
    end else if (flush_i) begin
      state       <= S_EMPTY;
      chk_valid_o <= 1'b0;
      chk_hart_o  <= '0;
      chk_rec_o   <= '0;
      last_grant  <= HW'(NUM_HARTS - 1);
    end else begin
      unique case (state)
        S_EMPTY: begin
          if (load) begin
            state       <= S_PRESENT;
            chk_valid_o <= 1'b1;
            chk_hart_o  <= grant;
            chk_rec_o   <= head[grant];
            last_grant  <= grant;
          end
        end
        S_PRESENT: begin
          if (chk_ready_i) begin
            if (load) begin
              chk_hart_o <= grant;
              chk_rec_o  <= head[grant];
              last_grant <= grant;
            end else begin
              state       <= S_EMPTY;
              chk_valid_o <= 1'b0;
            end
          end
        end
        default: begin
          state       <= S_EMPTY;
          chk_valid_o <= 1'b0;
        end
      endcase
    end
  end

  // Stall watchdog: counts consecutive held cycles, saturates, flag is sticky.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hang_cnt <= '0;
      hang_o   <= 1'b0;
    end else if (flush_i) begin
      hang_cnt <= '0;
      hang_o   <= 1'b0;
    end else if (chk_valid_o && !chk_ready_i) begin
      if (hang_cnt != TW'(TIMEOUT)) hang_cnt <= hang_cnt + 1'b1;
      if (hang_cnt == TW'(TIMEOUT - 1)) hang_o <= 1'b1;
    end else begin
      hang_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_cosim_commit_arbiter.sv
// Randomised and directed bench for cosim_commit_arbiter; a queue-based reference model
// predicts each delivered record and a negedge monitor compares everything the DUT shows.
module tb_cosim_commit_arbiter;

  localparam int NH = 4;
  localparam int FD = 8;
  localparam int RW = 168;
  localparam int TO = 16;
  localparam int HW = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush_i;
  logic [NH-1:0]    commit_valid_i;
  logic [NH*RW-1:0] commit_rec_i;
  logic [NH-1:0]    commit_ready_o;
  logic             chk_valid_o;
  logic [HW-1:0]    chk_hart_o;
  logic [RW-1:0]    chk_rec_o;
  logic             chk_ready_i;
  logic [NH-1:0]    overflow_o;
  logic             hang_o;

  int checks   = 0;
  int failures = 0;

  cosim_commit_arbiter #(
    .NUM_HARTS(NH), .FIFO_DEPTH(FD), .REC_W(RW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .commit_valid_i(commit_valid_i), .commit_rec_i(commit_rec_i),
    .commit_ready_o(commit_ready_o), .chk_valid_o(chk_valid_o),
    .chk_hart_o(chk_hart_o), .chk_rec_o(chk_rec_o), .chk_ready_i(chk_ready_i),
    .overflow_o(overflow_o), .hang_o(hang_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [HW-1:0] hart;
    logic [RW-1:0] rec;
  } exp_t;

  // Reference model: per-hart queues, one presentation slot, expected-output queue.
  logic [RW-1:0] mq [NH][$];
  exp_t          exp_q[$];
  logic          m_slot   = 1'b0;
  int            m_last   = NH - 1;
  logic [NH-1:0] m_ovf    = '0;
  int            m_hcnt   = 0;
  logic          m_hang   = 1'b0;
  int            m_sz [NH];
  int            m_g;

  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [RW-1:0] rand_rec();
    logic [191:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[RW-1:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int h, input logic [RW-1:0] r);
    commit_valid_i[h]          = 1'b1;
    commit_rec_i[h*RW +: RW]   = r;
  endtask

  task automatic model_clear();
    for (int h = 0; h < NH; h++) mq[h].delete();
    exp_q.delete();
    m_slot = 1'b0;
    m_last = NH - 1;
    m_ovf  = '0;
    m_hcnt = 0;
    m_hang = 1'b0;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_clear();
    end else if (flush_i) begin
      model_clear();
    end else begin
      for (int h = 0; h < NH; h++) m_sz[h] = mq[h].size();
      if (m_slot && !chk_ready_i) begin
        if (m_hcnt < TO) m_hcnt++;
        if (m_hcnt == TO) m_hang = 1'b1;
      end else begin
        m_hcnt = 0;
      end
      if (!m_slot || chk_ready_i) begin
        m_g = -1;
        for (int i = 1; i <= NH; i++) begin
          if (m_g < 0 && mq[(m_last + i) % NH].size() > 0) m_g = (m_last + i) % NH;
        end
        if (m_g >= 0) begin
          exp_q.push_back({HW'(m_g), mq[m_g].pop_front()});
          m_slot = 1'b1;
          m_last = m_g;
        end else begin
          m_slot = 1'b0;
        end
      end
      for (int h = 0; h < NH; h++) begin
        if (commit_valid_i[h]) begin
          if (m_sz[h] < FD) mq[h].push_back(commit_rec_i[h*RW +: RW]);
          else m_ovf[h] = 1'b1;
        end
      end
    end
  end

  // Monitor: compares presented record against the scoreboard head, pops on handshake.
  always @(negedge clk) begin
    logic [NH-1:0] er;
    for (int h = 0; h < NH; h++) er[h] = (mq[h].size() < FD);
    check("commit_ready", RW'(commit_ready_o), RW'(er));
    check("overflow", RW'(overflow_o), RW'(m_ovf));
    check("hang", RW'(hang_o), RW'(m_hang));
    check("chk_valid", RW'(chk_valid_o), RW'(m_slot));
    if (chk_valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL chk_unexpected: got hart %0d rec %0h expected no record at %0t",
                 chk_hart_o, chk_rec_o, $time);
      end else begin
        check("chk_hart", RW'(chk_hart_o), RW'(exp_q[0].hart));
        check("chk_rec", chk_rec_o, exp_q[0].rec);
        if (chk_ready_i) void'(exp_q.pop_front());
      end
    end
  end

  logic [RW-1:0] rec_a, rec_b;
  int            rr_exp [5] = '{1, 2, 3, 0, 1};

  initial begin
    rst = 1'b1; flush_i = 1'b0; commit_valid_i = '0; commit_rec_i = '0; chk_ready_i = 1'b0;
    step(); step();
    rst = 1'b0;
    check("reset_valid", RW'(chk_valid_o), RW'(1'b0));
    check("reset_ready", RW'(commit_ready_o), RW'(4'b1111));
    check("reset_hart", RW'(chk_hart_o), RW'(2'd0));
    check("reset_rec", chk_rec_o, '0);
    check("reset_ovf", RW'(overflow_o), RW'(4'b0000));

    // Single hart in order, latency 2
    rec_a = rand_rec(); rec_b = rand_rec();
    chk_ready_i = 1'b1;
    drive(2, rec_a); step();
    drive(2, rec_b); step();
    commit_valid_i = '0;
    check("inorder_v0", RW'(chk_valid_o), RW'(1'b1));
    check("inorder_h0", RW'(chk_hart_o), RW'(2'd2));
    check("inorder_a", chk_rec_o, rec_a);
    step();
    check("inorder_v1", RW'(chk_valid_o), RW'(1'b1));
    check("inorder_b", chk_rec_o, rec_b);
    step();
    check("inorder_idle", RW'(chk_valid_o), RW'(1'b0));

    // Round robin after hart 1
    flush_i = 1'b1; step(); flush_i = 1'b0;
    drive(1, rand_rec()); step();
    for (int h = 0; h < NH; h++) drive(h, rand_rec());
    step();
    commit_valid_i = '0;
    for (int k = 0; k < 5; k++) begin
      check("rr_valid", RW'(chk_valid_o), RW'(1'b1));
      check("rr_hart", RW'(chk_hart_o), RW'(rr_exp[k]));
      step();
    end

    // Overflow: 9 accepted, 10th dropped
    chk_ready_i = 1'b0;
    flush_i = 1'b1; step(); flush_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(0, rand_rec());
      if (i == 8) check("ovf_ready_c8", RW'(commit_ready_o[0]), RW'(1'b1));
      if (i == 9) check("ovf_ready_c9", RW'(commit_ready_o[0]), RW'(1'b0));
      step();
    end
    commit_valid_i = '0;
    check("ovf_flag", RW'(overflow_o), RW'(4'b0001));
    chk_ready_i = 1'b1;
    repeat (12) step();
    check("ovf_sticky", RW'(overflow_o[0]), RW'(1'b1));

    // Flush with pending records and a hart-1 commit in the flush cycle
    chk_ready_i = 1'b0;
    drive(0, rand_rec()); step(); commit_valid_i = '0;
    drive(2, rand_rec()); step(); commit_valid_i = '0;
    drive(3, rand_rec()); step(); commit_valid_i = '0;
    flush_i = 1'b1; drive(1, rand_rec()); step();
    flush_i = 1'b0; commit_valid_i = '0; chk_ready_i = 1'b1;
    check("flush_valid", RW'(chk_valid_o), RW'(1'b0));
    check("flush_ready", RW'(commit_ready_o), RW'(4'b1111));
    check("flush_ovf", RW'(overflow_o), RW'(4'b0000));
    repeat (3) step();
    check("flush_no_rec", RW'(chk_valid_o), RW'(1'b0));

    // Hang after TIMEOUT stalled cycles, sticky afterwards
    chk_ready_i = 1'b0;
    drive(3, rand_rec()); step();
    commit_valid_i = '0; step();
    repeat (15) step();
    check("hang_c17", RW'(hang_o), RW'(1'b0));
    step();
    check("hang_c18", RW'(hang_o), RW'(1'b1));
    chk_ready_i = 1'b1;
    repeat (3) step();
    check("hang_sticky", RW'(hang_o), RW'(1'b1));
    flush_i = 1'b1; step(); flush_i = 1'b0;

    // Random traffic with a stall-heavy window and a reset mid-traffic
    for (int c = 0; c < 600; c++) begin
      commit_valid_i = '0;
      for (int h = 0; h < NH; h++) begin
        commit_rec_i[h*RW +: RW] = rand_rec();
        if ($urandom_range(0, 9) < 4) commit_valid_i[h] = 1'b1;
      end
      if (c >= 100 && c < 200) chk_ready_i = ($urandom_range(0, 9) == 0);
      else                     chk_ready_i = ($urandom_range(0, 9) < 7);
      flush_i = ($urandom_range(0, 99) == 0);
      if (c == 300) begin
        rst = 1'b1;
        #1;
        check("rst_mid_valid", RW'(chk_valid_o), RW'(1'b0));
        check("rst_mid_ready", RW'(commit_ready_o), RW'(4'b1111));
        check("rst_mid_ovf", RW'(overflow_o), RW'(4'b0000));
        check("rst_mid_hang", RW'(hang_o), RW'(1'b0));
      end
      if (c == 301) rst = 1'b0;
      step();
    end

    commit_valid_i = '0; flush_i = 1'b0; chk_ready_i = 1'b1;
    repeat (50) step();
    check("drain_idle", RW'(chk_valid_o), RW'(1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
